// File: rtl/gate_truth_table_checker_pkg.sv
// Shared definitions for the gate self-test checker: FSM states, gate bit
// positions and result widths.
package gate_check_pkg;

  localparam int NUM_GATES = 7;
  localparam int ERR_W     = 8;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } checker_state_e;

endpackage

// File: rtl/gate_truth_table_checker_if.sv
// Control handshake, operand drive and gate return path of the checker,
// plus a debug view of the sequencer state.
interface gate_truth_table_checker_if;
  import gate_check_pkg::*;

  // Handshake: a one-cycle start is accepted only while idle (busy=0, done=0);
  // busy stays high from the cycle after acceptance through the last check,
  // then done pulses for exactly one cycle with pass/fail_mask/err_count valid.
  // Results hold until the next accepted start.
  logic                 start;
  logic                 a_out;
  logic                 b_out;
  logic [NUM_GATES-1:0] gate_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_GATES-1:0] fail_mask;
  logic [ERR_W-1:0]     err_count;
  logic [1:0]           vec_idx;
  checker_state_e       dbg_state;

  modport master (
    output start, gate_in,
    input  a_out, b_out, busy, done, pass, fail_mask, err_count, vec_idx, dbg_state
  );

  modport slave (
    input  start, gate_in,
    output a_out, b_out, busy, done, pass, fail_mask, err_count, vec_idx, dbg_state
  );

endinterface

// File: rtl/gate_truth_table_checker_golden.sv
// Reference model of the basic-gates block: maps (a,b) to the seven
// expected gate outputs in gate bit order.
module gate_golden_model
  import gate_check_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] golden
);

  always_comb begin
    golden            = '0;
    golden[GATE_AND]  = a & b;
    golden[GATE_OR]   = a | b;
    golden[GATE_NOT]  = ~a;
    golden[GATE_NAND] = ~(a & b);
    golden[GATE_NOR]  = ~(a | b);
    golden[GATE_XOR]  = a ^ b;
    golden[GATE_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Self-test sequencer: sweeps the gate block through its 2-input truth table
// ROUNDS times and accumulates a per-gate failure mask and mismatch count.
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ROUNDS        = 1
) (
  input logic                       clk,
  input logic                       rst,
  gate_truth_table_checker_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [RND_W-1:0] LAST_ROUND  = RND_W'(ROUNDS - 1);

  checker_state_e       state_q, state_d;
  logic                 a_out_q, a_out_d;
  logic                 b_out_q, b_out_d;
  logic [1:0]           vec_q, vec_d;
  logic [RND_W-1:0]     round_q, round_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_GATES-1:0] mask_q, mask_d;
  logic [ERR_W-1:0]     err_q, err_d;

  logic [NUM_GATES-1:0] golden_vec;
  logic [NUM_GATES-1:0] diff;
  logic [ERR_W-1:0]     err_next;
  logic [1:0]           vec_next;

  // Golden is evaluated from the registered operands, so it always matches
  // what the gate block is currently seeing.
  gate_golden_model u_golden (
    .a      (a_out_q),
    .b      (b_out_q),
    .golden (golden_vec)
  );

  assign diff     = bus.gate_in ^ golden_vec;
  assign err_next = ((|diff) && (err_q != ERR_MAX)) ? err_q + 1'b1 : err_q;
  assign vec_next = vec_q + 2'd1;

  always_comb begin
    state_d = state_q;
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    vec_d   = vec_q;
    round_d = round_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          round_d = '0;
          a_out_d = 1'b0;
          b_out_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (SETTLE_CYCLES > 0) begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end

      ST_CHECK: begin
        mask_d = mask_q | diff;
        err_d  = err_next;
        if (vec_q == 2'd3 && round_q == LAST_ROUND) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
          state_d = ST_DONE;
        end else begin
          // Operands for the next vector are registered on entry to DRIVE
          // so they are stable for the whole DRIVE..CHECK window.
          vec_d   = vec_next;
          a_out_d = vec_next[1];
          b_out_d = vec_next[0];
          if (vec_q == 2'd3) round_d = round_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_out_q <= 1'b0;
      b_out_q <= 1'b0;
      vec_q   <= 2'd0;
      round_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      vec_q   <= vec_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;
  assign bus.err_count = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/gate_truth_table_checker.md
# gate_truth_table_checker

Self-test sequencer that sits around the combinational basic-gates block: it drives the gate block's two operand inputs through the full 2-input truth table and captures the block's seven gate outputs on the return path. Each captured result is compared against a golden model. The checker accumulates a per-gate failure mask and a mismatch count, and reports pass/fail through a start/done handshake. It is the bring-up and regression harness for the gates stage, synthesisable for on-board self-test.

## Interface
Parameters:
- SETTLE_CYCLES, 1, wait cycles between driving operands and sampling gate outputs (0 allowed)
- ROUNDS, 1, number of full 4-vector sweeps per run (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  run request; accepted only in IDLE
- a_out  output  1  operand a to gate block
- b_out  output  1  operand b to gate block
- gate_in  input  7  gate block outputs: [0] and, [1] or, [2] not(a), [3] nand, [4] nor, [5] xor, [6] xnor
- busy  output  1  high from the cycle after start acceptance through the last CHECK
- done  output  1  one-cycle pulse at end of run
- pass  output  1  valid after done, high iff err_count==0; low while busy
- fail_mask  output  7  sticky OR of per-bit mismatches over the run
- err_count  output  8  number of CHECK cycles with any mismatch; saturates at 255
- vec_idx  output  2  current vector index, {a_out,b_out}

## Operation
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: on start=1, clear fail_mask, err_count, pass; set vec_idx=0, round=0; go to DRIVE.
- DRIVE (1 cycle): a_out=vec_idx[1], b_out=vec_idx[0] (registered). Go to SETTLE if SETTLE_CYCLES>0, else go to CHECK.
- SETTLE (SETTLE_CYCLES cycles): down-counter, operands held, then go to CHECK.
- CHECK (1 cycle): sample gate_in; diff = gate_in ^ golden(a_out,b_out); fail_mask |= diff; if diff≠0, err_count += 1 (hold at 255).
  - If vec_idx==3 and round==ROUNDS-1, go to DONE.
  - Otherwise vec_idx wraps 3→0 (round += 1 on wrap); go to DRIVE.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0, including the final CHECK's update); go to IDLE.
- Vector order per round: (a,b) = 00, 01, 10, 11.
- golden(a,b) = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}, MSB first.
- start is ignored in every state except IDLE (no queuing).
- Results hold in IDLE until the next accepted start.
- a_out/b_out hold their last value in IDLE/DONE.

## Timing
- Reset values: state IDLE; a_out=0, b_out=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0.
- rst during a run aborts immediately: no done pulse; outputs take reset values next edge.
- start at edge k: DRIVE at k+1, busy=1 from k+1.
- Per vector: 2+SETTLE_CYCLES cycles.
- Run length, start accept to done pulse: 4·ROUNDS·(2+SETTLE_CYCLES) cycles, then done for 1 cycle.
- Default parameters: 12 cycles of busy, done on cycle 13 after acceptance.
- gate_in is sampled only in CHECK; its value in other states is don't-care.
- Operands are stable from DRIVE through CHECK of each vector. The gate block must settle within SETTLE_CYCLES+1 cycles.

## Structure
- Package gate_check_pkg holds:
  - FSM state enum
  - gate bit-index localparams (GATE_AND=0 … GATE_XNOR=6)
  - NUM_GATES=7
  - ERR_W=8
- Sub-module gate_golden_model: purely combinational (a,b) → 7-bit expected vector. It is instantiated once and reusable by benches.
- Top holds the FSM, settle counter, round counter, and result registers.

## Test plan
- Correct gate block attached, defaults: pulse start → done exactly 13 cycles after acceptance; pass=1, fail_mask=0, err_count=0; vec_idx sequence 0,1,2,3.
- xor bit stuck at 0: pass=0, fail_mask=7'b0100000, err_count=2 (vectors 01 and 10).
- SETTLE_CYCLES=0, ROUNDS=2, nand inverted: run is 16 cycles; fail_mask=7'b0001000, err_count=8.
- ROUNDS=64, gate_in=~golden: 256 mismatches → err_count saturates at 255, fail_mask=7'h7F, pass=0.
- start re-asserted while busy, and in the DONE cycle: ignored, no restart, single done pulse; a later start in IDLE clears results and reruns.
- rst asserted mid-SETTLE of vector 2: next edge all outputs at reset values, no done pulse; a subsequent start runs a full clean pass.
